// File: rtl/muldiv_iter_if.sv
// Request/response bundle between the EX stage and the shared multiply/divide engine.
// Handshake: start_i is sampled only while the engine is idle; ready_o is a one-cycle
// pulse during which result_o (and div_zero_o) are valid, and result_o holds afterwards.
interface muldiv_iter_if #(
    parameter int WIDTH = 32
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [WIDTH-1:0]   opdata1_i;
    logic [WIDTH-1:0]   opdata2_i;
    logic               annul_i;
    logic               busy_o;
    logic               ready_o;
    logic               div_zero_o;
    logic [2*WIDTH-1:0] result_o;

    modport master (
        output start_i, op_i, opdata1_i, opdata2_i, annul_i,
        input  busy_o, ready_o, div_zero_o, result_o
    );

    modport slave (
        input  start_i, op_i, opdata1_i, opdata2_i, annul_i,
        output busy_o, ready_o, div_zero_o, result_o
    );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// with annul, divide-by-zero short-cut and a one-cycle sign-fix stage.
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic         clk,
    input  logic         resetn,
    muldiv_iter_if.slave bus,
    output logic [1:0]   o_dbg_state
);
    localparam int W = WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [W-1:0]     ONE_W    = W'(1);
    localparam logic [2*W-1:0]   ONE_2W   = (2 * W)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [1:0]       r_op;
    logic             r_sign1;
    logic             r_sign2;
    logic [CNT_W-1:0] r_cnt;
    logic [2*W-1:0]   r_acc;
    logic [W-1:0]     r_opb;
    logic             r_busy;
    logic             r_ready;
    logic             r_dz;
    logic [2*W-1:0]   r_result;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [W-1:0]     w_a_mag;
    logic [W-1:0]     w_b_mag;
    logic             w_div_zero;
    logic             w_accept;
    logic [W:0]       w_mul_add;
    logic [2*W-1:0]   w_mul_next;
    logic [W:0]       w_rem_sh;
    logic             w_ge;
    logic [W-1:0]     w_trial;
    logic [2*W-1:0]   w_div_next;
    logic [2*W-1:0]   w_prod_neg;
    logic [W-1:0]     w_quot_neg;
    logic [W-1:0]     w_rem_neg;
    logic [2*W-1:0]   w_fixed;

    // Magnitudes of MIN wrap back to MIN, which reads correctly as unsigned 2^(W-1).
    assign w_a_neg    = bus.op_i[0] & bus.opdata1_i[W-1];
    assign w_b_neg    = bus.op_i[0] & bus.opdata2_i[W-1];
    assign w_a_mag    = w_a_neg ? (~bus.opdata1_i + ONE_W) : bus.opdata1_i;
    assign w_b_mag    = w_b_neg ? (~bus.opdata2_i + ONE_W) : bus.opdata2_i;
    assign w_div_zero = bus.op_i[1] & (bus.opdata2_i == {W{1'b0}});
    assign w_accept   = bus.start_i & ~bus.annul_i;

    // Shift-add: multiplier sits in the low half and drains out as the product fills in.
    assign w_mul_add  = {1'b0, r_acc[2*W-1:W]} + {1'b0, (r_acc[0] ? r_opb : {W{1'b0}})};
    assign w_mul_next = {w_mul_add, r_acc[W-1:1]};

    // Restoring divide: the shifted remainder may need W+1 bits before the trial subtract.
    assign w_rem_sh   = r_acc[2*W-1:W-1];
    assign w_ge       = (w_rem_sh >= {1'b0, r_opb});
    assign w_trial    = w_rem_sh[W-1:0] - r_opb;
    assign w_div_next = w_ge ? {w_trial, r_acc[W-2:0], 1'b1}
                             : {w_rem_sh[W-1:0], r_acc[W-2:0], 1'b0};

    assign w_prod_neg = ~r_acc + ONE_2W;
    assign w_quot_neg = ~r_acc[W-1:0] + ONE_W;
    assign w_rem_neg  = ~r_acc[2*W-1:W] + ONE_W;

    always_comb begin
        w_fixed = r_acc;
        if (r_op[1]) begin
            w_fixed[W-1:0]   = (r_sign1 ^ r_sign2) ? w_quot_neg : r_acc[W-1:0];
            w_fixed[2*W-1:W] = r_sign1 ? w_rem_neg : r_acc[2*W-1:W];
        end else if (r_sign1 ^ r_sign2) begin
            w_fixed = w_prod_neg;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_op     <= 2'b00;
            r_sign1  <= 1'b0;
            r_sign2  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_busy   <= 1'b0;
            r_ready  <= 1'b0;
            r_dz     <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= bus.op_i;
                        r_sign1 <= w_a_neg;
                        r_sign2 <= w_b_neg;
                        r_cnt   <= '0;
                        if (w_div_zero) begin
                            r_result <= {bus.opdata1_i, {W{1'b1}}};
                            r_dz     <= 1'b1;
                            r_ready  <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_opb   <= bus.op_i[1] ? w_b_mag : w_a_mag;
                            r_acc   <= {{W{1'b0}}, (bus.op_i[1] ? w_a_mag : w_b_mag)};
                            r_busy  <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (bus.annul_i) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= r_op[1] ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CNT_ONE;
                        if (r_cnt == LAST_CNT) begin
                            r_state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    r_busy <= 1'b0;
                    if (bus.annul_i) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_result <= w_fixed;
                        r_ready  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ready <= 1'b0;
                    r_dz    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy_o     = r_busy;
    assign bus.ready_o    = r_ready;
    assign bus.div_zero_o = r_dz;
    assign bus.result_o   = r_result;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_muldiv_iter.sv
// Directed and randomized checks of muldiv_iter at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model.
module tb_muldiv_iter;
  logic       clk = 1'b0;
  logic       resetn;
  logic [1:0] st32;
  logic [1:0] st8;

  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) b32();
  muldiv_iter_if #(.WIDTH(8))  b8();

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut32 (
    .clk(clk), .resetn(resetn), .bus(b32.slave), .o_dbg_state(st32)
  );
  muldiv_iter #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .resetn(resetn), .bus(b8.slave), .o_dbg_state(st8)
  );

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res[2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on sign-extended operands.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input int w);
    longint mask, sa, sb, p, q, r;
    mask = (longint'(1) << w) - 1;
    sa = longint'(a) & mask;
    sb = longint'(b) & mask;
    if (op[0]) begin
      if (sa[w-1]) sa = sa - (longint'(1) << w);
      if (sb[w-1]) sb = sb - (longint'(1) << w);
    end
    if (!op[1]) begin
      p = sa * sb;
      if (w < 32) p = p & ((longint'(1) << (2 * w)) - 1);
      return 64'(p);
    end
    if (sb == 0) return 64'(((sa & mask) << w) | mask);
    q = sa / sb;
    r = sa % sb;
    return 64'(((r & mask) << w) | (q & mask));
  endfunction

  task automatic drive(input int sel, input logic s, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic an);
    if (sel == 1) begin
      b8.start_i = s; b8.op_i = op; b8.opdata1_i = a[7:0]; b8.opdata2_i = b[7:0]; b8.annul_i = an;
    end else begin
      b32.start_i = s; b32.op_i = op; b32.opdata1_i = a; b32.opdata2_i = b; b32.annul_i = an;
    end
  endtask

  task automatic peek(input int sel, output logic busy, output logic ready, output logic dz,
                      output logic [63:0] res, output logic [1:0] st);
    if (sel == 1) begin
      busy = b8.busy_o; ready = b8.ready_o; dz = b8.div_zero_o;
      res = {48'b0, b8.result_o}; st = st8;
    end else begin
      busy = b32.busy_o; ready = b32.ready_o; dz = b32.div_zero_o;
      res = b32.result_o; st = st32;
    end
  endtask

  // One operation: start, watch a bounded window, then check latency, pulse count,
  // result, flag, busy length and that the result holds afterwards.
  task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a_in,
                        input logic [31:0] b_in, input string tag, input int extra_at,
                        output logic [63:0] got);
    int          w, lat, nready, nbusy, exp_lat, exp_busy;
    logic        busy, ready, dz, got_dz, exp_dz;
    logic [31:0] a, b;
    logic [63:0] res, exp;
    logic [1:0]  st;
    w = (sel == 1) ? 8 : 32;
    a = (sel == 1) ? (a_in & 32'hFF) : a_in;
    b = (sel == 1) ? (b_in & 32'hFF) : b_in;
    exp_q.push_back(ref_model(op, a, b, w));
    exp_dz   = op[1] && (b == 32'd0);
    exp_lat  = exp_dz ? 1 : w + 2;
    exp_busy = exp_dz ? 0 : w + 1;
    lat = 0; nready = 0; nbusy = 0; got = '0; got_dz = 1'b0;
    @(negedge clk);
    drive(sel, 1'b1, op, a, b, 1'b0);
    for (int k = 1; k <= w + 8; k++) begin
      @(negedge clk);
      peek(sel, busy, ready, dz, res, st);
      if (busy) nbusy++;
      if (ready) begin
        nready++;
        if (lat == 0) begin lat = k; got = res; got_dz = dz; end
      end
      drive(sel, (k == extra_at), 2'($urandom), $urandom, $urandom, 1'b0);
    end
    exp = exp_q.pop_front();
    check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    check({tag, ".ready_pulses"}, 64'(nready), 64'd1);
    check({tag, ".result"}, got, exp);
    check({tag, ".div_zero"}, 64'(got_dz), 64'(exp_dz));
    check({tag, ".busy_cycles"}, 64'(nbusy), 64'(exp_busy));
    peek(sel, busy, ready, dz, res, st);
    check({tag, ".result_hold"}, res, exp);
    check({tag, ".idle_after"}, {61'b0, busy, st}, 64'd0);
    last_res[sel] = exp;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 300));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic        busy, ready, dz;
    logic [63:0] res, got, prev;
    logic [1:0]  st;
    int          nready;

    // Clock/reset block
    resetn = 1'b0;
    drive(0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    drive(1, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    #12;
    peek(0, busy, ready, dz, res, st);
    check("reset32.outputs", {res[60:0], busy, ready, dz}, 64'd0);
    check("reset32.state", 64'(st), 64'd0);
    peek(1, busy, ready, dz, res, st);
    check("reset8.outputs", {res[60:0], busy, ready, dz}, 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Directed cases
    run_op(0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max", -1, got);
    check("multu_max.const", got, 64'hFFFF_FFFE_0000_0001);
    run_op(0, 2'b01, 32'hFFFF_FFF9, 32'd3, "mult_neg7x3", -1, got);
    check("mult_neg7x3.const", got, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(0, 2'b11, 32'hFFFF_FFF9, 32'd2, "div_neg7by2", -1, got);
    check("div_neg7by2.const", got, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(0, 2'b10, 32'd100, 32'd0, "divu_by0", -1, got);
    check("divu_by0.const", got, 64'h0000_0064_FFFF_FFFF);
    run_op(0, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_by_m1", -1, got);
    check("div_min_by_m1.const", got, 64'h0000_0000_8000_0000);

    // Annul at CALC cycle 10: no pulse, result unchanged
    prev = last_res[0];
    nready = 0;
    @(negedge clk);
    drive(0, 1'b1, 2'b10, 32'd50, 32'd7, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      peek(0, busy, ready, dz, res, st);
      if (ready) nready++;
      if (k == 11) check("annul.calc_state", 64'(st), 64'd1);
      if (k == 12) check("annul.idle_next", {61'b0, busy, st}, 64'd0);
      drive(0, 1'b0, 2'b10, 32'd50, 32'd7, (k == 11));
    end
    check("annul.no_ready", 64'(nready), 64'd0);
    check("annul.result_kept", res, prev);
    run_op(0, 2'b00, 32'd6, 32'd7, "multu_6x7", -1, got);
    check("multu_6x7.const", got, 64'd42);

    // start_i during CALC and during DONE is ignored
    run_op(0, 2'b01, $urandom, $urandom, "mult_start_in_calc", 5, got);
    run_op(0, 2'b11, $urandom, 32'd13, "div_start_in_done", 34, got);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    drive(0, 1'b1, 2'b00, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      drive(0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0);
    end
    #2 resetn = 1'b0;
    #1;
    peek(0, busy, ready, dz, res, st);
    check("async_reset.outputs", {res[60:0], busy, ready, dz}, 64'd0);
    check("async_reset.state", 64'(st), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_op(0, 2'b10, 32'd1000, 32'd7, "divu_after_reset", -1, got);

    // WIDTH = 8 instance
    run_op(1, 2'b00, 32'hFF, 32'hFF, "w8_multu_ff", -1, got);
    check("w8_multu_ff.const", got, 64'hFE01);
    run_op(1, 2'b11, 32'h80, 32'hFF, "w8_div_min_by_m1", -1, got);
    run_op(1, 2'b01, 32'h80, 32'h80, "w8_mult_min_sq", -1, got);

    // Randomized stimulus
    for (int i = 0; i < 30; i++) begin
      run_op(0, 2'($urandom_range(0, 3)), pick(), pick(), "rand32", -1, got);
    end
    for (int i = 0; i < 16; i++) begin
      run_op(1, 2'($urandom_range(0, 3)), $urandom, 32'($urandom_range(0, 255)), "rand8", -1, got);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
